// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents:
//   state_e - sequencer state encoding (IDLE=0, RUN=1, DONE=2)
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_sub.sv
// seq_divider_sub: unsigned N-bit subtractor, the divider's only arithmetic unit.
// Ports:
//   a    in  N  minuend
//   b    in  N  subtrahend
//   z    out N  a - b (modulo 2^N)
//   cout out 1  carry out; 1 means no borrow (a >= b)
module seq_divider_sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] z,
  output logic         cout
);

  logic [N:0] sum_s;

  // Two's-complement subtract; the carry out of the top bit is the no-borrow flag.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    z     = sum_s[N-1:0];
    cout  = sum_s[N];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned N-bit restoring divider producing one quotient bit per clock.
// Ports:
//   clk          in  1  rising-edge clock
//   rst          in  1  synchronous active-high reset
//   start        in  1  request, accepted only while not busy
//   dividend     in  N  numerator, sampled on the accepting edge
//   divisor      in  N  denominator, sampled on the accepting edge
//   busy         out 1  high while iterating
//   done         out 1  one-cycle pulse when results become valid
//   quotient     out N  result, held until the next accepted start
//   remainder    out N  result, held until the next accepted start
//   div_by_zero  out 1  set with done when divisor was zero, held like results
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N-1:0]     DIV_ZERO_Q = {N{1'b1}};

  state_e           state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     r_q, r_d;
  logic [N-1:0]     d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Partial remainder shifted left with the next dividend bit; N+1 bits since R < D.
  logic [N:0] sub_a_s;
  logic [N:0] sub_z_s;
  logic       sub_cout_s;

  assign sub_a_s = {r_q, q_q[N-1]};

  seq_divider_sub #(.N(N + 1)) u_sub (
    .a    (sub_a_s),
    .b    ({1'b0, d_q}),
    .z    (sub_z_s),
    .cout (sub_cout_s)
  );

  // Next-state and datapath update for the whole sequencer.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != {N{1'b0}}) begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = {N{1'b0}};
            cnt_d   = CNT_INIT;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            // Zero divisor resolves immediately with the conventional all-ones quotient.
            q_d     = DIV_ZERO_Q;
            r_d     = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Restore decision: keep the difference only when the trial subtract did not borrow.
        if (sub_cout_s) begin
          r_d = sub_z_s[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = sub_a_s[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= {N{1'b0}};
      r_q     <= {N{1'b0}};
      d_q     <= {N{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (N=32). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests_run;
  int tests_failed;

  seq_divider #(.N(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present start for one cycle, then count cycles until done (bounded).
  // Returned count is the number of cycles from the start cycle to the done cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int cycles);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    cycles   = 1;
    while (done !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = 32'd0;
    divisor = 32'd0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h, required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (cyc != 33) begin
      tests_failed++;
      $display("FAIL basic_latency: %0d cycles, required 33", cyc);
    end
    tests_run++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_100_7: q=%0d r=%0d dbz=%b, required q=14 r=2 dbz=0",
               quotient, remainder, div_by_zero);
    end
    // Results hold and done drops once the pulse is over.
    repeat (3) @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
      tests_failed++;
      $display("FAIL basic_hold: done=%b busy=%b q=%0d r=%0d, required 0 0 14 2",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    int cyc;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;           eq[0] = 32'hFFFF_FFFF; er[0] = 32'd0;
    va[1] = 32'd3;         vb[1] = 32'd10;          eq[1] = 32'd0;         er[1] = 32'd3;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;   eq[2] = 32'd1;         er[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], cyc);
      tests_run++;
      if (cyc != 33 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        tests_failed++;
        $display("FAIL boundary_%0d: %h/%h cyc=%0d q=%h r=%h dbz=%b, required cyc=33 q=%h r=%h dbz=0",
                 i, va[i], vb[i], cyc, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    run_div(32'd5, 32'd0, cyc);
    tests_run++;
    if (cyc != 1) begin
      tests_failed++;
      $display("FAIL dbz_latency: %0d cycles, required 1", cyc);
    end
    tests_run++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required q=ffffffff r=5 dbz=1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    tests_run++;
    if (div_by_zero !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbz_hold: dbz=%b done=%b, required dbz=1 done=0", div_by_zero, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (c == 10) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_start: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_run_reset: busy=%b done=%b dbz=%b q=%h r=%h, required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    // No stale completion from the discarded operation.
    repeat (15) @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL discarded_op: done=%b busy=%b, required 0 0", done, busy);
    end
    run_div(32'd9, 32'd2, cyc);
    tests_run++;
    if (cyc != 33 || quotient !== 32'd4 || remainder !== 32'd1) begin
      tests_failed++;
      $display("FAIL after_reset_9_2: cyc=%0d q=%0d r=%0d, required cyc=33 q=4 r=1",
               cyc, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_div(32'd50, 32'd5, cyc);
    tests_run++;
    if (cyc != 33 || quotient !== 32'd10 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_first: cyc=%0d q=%0d r=%0d, required cyc=33 q=10 r=0",
               cyc, quotient, remainder);
    end
    // Still in the done cycle: the next start is accepted with no gap.
    run_div(32'd7, 32'd7, cyc);
    tests_run++;
    if (cyc != 33) begin
      tests_failed++;
      $display("FAIL b2b_spacing: %0d cycles between done pulses, required 33", cyc);
    end
    tests_run++;
    if (quotient !== 32'd1 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: q=%0d r=%0d dbz=%b, required q=1 r=0 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = 32'd0;
    divisor = 32'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
